// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// States, opcodes, ALUOp codes and mux select encodings live here.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        RWB    = 4'd7,
        EXEC_I = 4'd8,
        IWB    = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_FUNC = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
        logic       bus_err;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_imm_alu_dec.sv
// I-type opcode to ALUOp / immediate-extension decode.
// Purely combinational; only meaningful while in EXEC_I.
module imm_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] alu_op,
    output logic       ext_zero
);

    always_comb begin
        alu_op   = ALU_ADD;
        ext_zero = 1'b0;
        case (opcode)
            OP_SLTI:  alu_op = ALU_SLT;
            OP_SLTIU: alu_op = ALU_SLTU;
            OP_ANDI: begin
                alu_op   = ALU_AND;
                ext_zero = 1'b1;
            end
            OP_ORI: begin
                alu_op   = ALU_OR;
                ext_zero = 1'b1;
            end
            OP_XORI: begin
                alu_op   = ALU_XOR;
                ext_zero = 1'b1;
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// Memory states wait on mem_ready with a bounded timeout.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    ctrl_t           ctrl;
    logic [2:0]      imm_op;
    logic            imm_ext;
    logic            timeout;

    imm_alu_dec u_imm_dec (
        .opcode   (opcode),
        .alu_op   (imm_op),
        .ext_zero (imm_ext)
    );

    assign timeout = !mem_ready && (cnt_q == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_d stays zero except while a wait state is held, so every
    // entry into FETCH/MEMRD/MEMWR starts from a cleared counter.
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_en    = 1'b1;
                    state_d       = DECODE;
                end else if (timeout) begin
                    ctrl.bus_err = 1'b1;
                    state_d      = FETCH;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:        state_d = EXEC_R;
                    OP_LW, OP_SW:    state_d = MEMADR;
                    OP_BEQ, OP_BNE:  state_d = BRANCH;
                    OP_J:            state_d = JUMP;
                    OP_ADDI, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI:
                                     state_d = EXEC_I;
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_d      = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end else if (timeout) begin
                    ctrl.bus_err = 1'b1;
                    state_d      = FETCH;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = FETCH;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    ctrl.bus_err = 1'b1;
                    state_d      = FETCH;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNC;
                state_d        = RWB;
            end
            RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = FETCH;
            end
            EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = imm_op;
                ctrl.ext_zero  = imm_ext;
                state_d        = IWB;
            end
            IWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = FETCH;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_en     = (opcode == OP_BNE) ? !zero : zero;
                state_d        = FETCH;
            end
            JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_en     = 1'b1;
                state_d        = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset masks every output so no write escapes the reset cycle.
    assign {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero,
            alu_op, pc_source, illegal, bus_err} = reset ? '0 : ctrl;

    assign state = reset ? 4'(FETCH) : 4'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus
// randomized instruction streams against an instruction-level model.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal, bus_err;
    logic [3:0] state;

    logic [5:0] dop = '0;
    logic [2:0] dalu;
    logic       dext;

    int checks = 0;
    int errors = 0;

    state_t ms = FETCH;
    int     mw = 0;
    state_t plan[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_zero(ext_zero), .alu_op(alu_op), .pc_source(pc_source),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    imm_alu_dec u_dec (.opcode(dop), .alu_op(dalu), .ext_zero(dext));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {ext_zero, alu_op} expected for the six I-type ALU opcodes
    function automatic logic [3:0] imm_ref(input logic [5:0] o);
        case (o)
            OP_SLTI:  return 4'b0101;
            OP_SLTIU: return 4'b0110;
            OP_ANDI:  return 4'b1010;
            OP_ORI:   return 4'b1011;
            OP_XORI:  return 4'b1100;
            default:  return 4'b0000;
        endcase
    endfunction

    // Remaining states of an instruction once its fetch completes.
    task automatic build_plan(input logic [5:0] o);
        plan.delete();
        plan.push_back(DECODE);
        case (o)
            OP_RTYPE: begin plan.push_back(EXEC_R); plan.push_back(RWB); end
            OP_LW: begin
                plan.push_back(MEMADR); plan.push_back(MEMRD);
                plan.push_back(MEMWB);
            end
            OP_SW: begin plan.push_back(MEMADR); plan.push_back(MEMWR); end
            OP_BEQ, OP_BNE: plan.push_back(BRANCH);
            OP_J: plan.push_back(JUMP);
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                plan.push_back(EXEC_I); plan.push_back(IWB);
            end
            default: ;
        endcase
    endtask

    function automatic ctrl_t model_out();
        ctrl_t c;
        logic  to;
        logic [3:0] ie;
        c  = '0;
        if (reset) return c;
        to = !mem_ready && (mw == TMO - 1);
        ie = imm_ref(opcode);
        case (ms)
            FETCH: begin
                c.mem_read = 1; c.alu_src_b = 2'b01;
                c.ir_write = mem_ready; c.pc_en = mem_ready; c.bus_err = to;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.illegal = (plan.size() == 0);
            end
            MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            MEMRD: begin c.mem_read = 1; c.iord = 1; c.bus_err = to; end
            MEMWB: begin c.reg_write = 1; c.mem_to_reg = 1; end
            MEMWR: begin c.mem_write = 1; c.iord = 1; c.bus_err = to; end
            EXEC_R: begin c.alu_src_a = 1; c.alu_op = 3'b111; end
            RWB: begin c.reg_write = 1; c.reg_dst = 1; end
            EXEC_I: begin
                c.alu_src_a = 1; c.alu_src_b = 2'b10;
                c.alu_op = ie[2:0]; c.ext_zero = ie[3];
            end
            IWB: c.reg_write = 1;
            BRANCH: begin
                c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_source = 2'b01;
                c.pc_en = (opcode == OP_BEQ) ? zero : !zero;
            end
            JUMP: begin c.pc_source = 2'b10; c.pc_en = 1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic advance();
        if (reset) begin
            ms = FETCH; mw = 0; plan.delete();
        end else if (ms == FETCH || ms == MEMRD || ms == MEMWR) begin
            if (mem_ready) begin
                if (ms == FETCH) build_plan(opcode);
                ms = (plan.size() != 0) ? plan.pop_front() : FETCH;
                mw = 0;
            end else if (mw == TMO - 1) begin
                ms = FETCH; mw = 0; plan.delete();
            end else begin
                mw++;
            end
        end else begin
            ms = (plan.size() != 0) ? plan.pop_front() : FETCH;
            mw = 0;
        end
    endtask

    task automatic cyc(input logic [5:0] o, input logic z,
                       input logic r, input logic rs);
        ctrl_t act;
        ctrl_t exp;
        opcode = o; zero = z; mem_ready = r; reset = rs;
        #1;
        act = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero,
               alu_op, pc_source, illegal, bus_err};
        exp = model_out();
        check("state", int'(state), reset ? int'(FETCH) : int'(ms));
        check("outputs", int'(act), int'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic fetch_dec(input logic [5:0] o);
        cyc(o, 0, 1, 0); tick();
        cyc(o, 0, 0, 0); tick();
    endtask

    logic [5:0] ops [16] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                             OP_J, OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
                             OP_ORI, OP_XORI, 6'h3f, 6'h11, OP_LW, OP_SW};

    initial begin
        logic [5:0] op;
        logic       slow;
        op = OP_RTYPE;
        slow = 1'b0;

        for (int i = 6; i < 12; i++) begin
            dop = ops[i];
            #1;
            check("imm_dec", int'({dext, dalu}), int'(imm_ref(ops[i])));
        end
        dop = OP_ORI; #1;
        check("imm_dec_ori_lit", int'({dext, dalu}), 4'hb);

        @(posedge clk); #1;
        cyc(0, 0, 1, 1);
        check("rst_state", int'(state), 0);
        check("rst_memread", int'(mem_read), 0);
        tick();
        cyc(0, 0, 1, 1); tick();

        cyc(OP_RTYPE, 0, 1, 0);
        check("add_fetch_irw", int'({ir_write, pc_en}), 3);
        tick();
        cyc(OP_RTYPE, 0, 0, 0); check("add_dec", int'(state), 1); tick();
        cyc(OP_RTYPE, 0, 0, 0); check("add_exec", int'(alu_op), 7); tick();
        cyc(OP_RTYPE, 0, 0, 0);
        check("add_rwb", int'({reg_write, reg_dst}), 3);
        tick();

        fetch_dec(OP_LW);
        cyc(OP_LW, 0, 0, 0); check("lw_memadr", int'(state), 2); tick();
        for (int i = 0; i < 4; i++) begin
            cyc(OP_LW, 0, (i == 3), 0);
            check("lw_memrd", int'(state), 3);
            tick();
        end
        cyc(OP_LW, 0, 0, 0);
        check("lw_memwb", int'({reg_write, mem_to_reg}), 3);
        tick();

        fetch_dec(OP_SW);
        cyc(OP_SW, 0, 0, 0); tick();
        cyc(OP_SW, 0, 0, 0);
        check("sw_wr", int'({mem_write, reg_write}), 2);
        tick();
        cyc(OP_SW, 0, 1, 0); check("sw_wr_rdy", int'(mem_write), 1); tick();
        cyc(OP_SW, 0, 0, 0); check("sw_done", int'(state), 0);

        fetch_dec(OP_BEQ);
        cyc(OP_BEQ, 1, 0, 0);
        check("beq_z1", int'({pc_en, pc_source, alu_op}), 6'b1_01_001);
        tick();
        fetch_dec(OP_BEQ);
        cyc(OP_BEQ, 0, 0, 0); check("beq_z0", int'(pc_en), 0); tick();
        fetch_dec(OP_BNE);
        cyc(OP_BNE, 0, 0, 0); check("bne_z0", int'(pc_en), 1); tick();
        fetch_dec(OP_BNE);
        cyc(OP_BNE, 1, 0, 0); check("bne_z1", int'(pc_en), 0); tick();

        fetch_dec(OP_ORI);
        cyc(OP_ORI, 0, 0, 0);
        check("ori_exec", int'({ext_zero, alu_op}), 4'b1011);
        tick();
        cyc(OP_ORI, 0, 0, 0);
        check("ori_iwb", int'({reg_write, reg_dst}), 2);
        tick();
        fetch_dec(OP_SLTI);
        cyc(OP_SLTI, 0, 0, 0);
        check("slti_exec", int'({ext_zero, alu_op}), 4'b0101);
        tick();
        cyc(OP_SLTI, 0, 0, 0);
        check("slti_iwb", int'({reg_write, reg_dst}), 2);
        tick();

        fetch_dec(OP_LW);
        cyc(OP_LW, 0, 0, 0); tick();
        for (int i = 0; i < TMO; i++) begin
            cyc(OP_LW, 0, 0, 0);
            check("to_buserr", int'(bus_err), (i == TMO - 1) ? 1 : 0);
            tick();
        end
        cyc(OP_LW, 0, 0, 0);
        check("to_after", int'({state, reg_write}), 0);
        tick();
        cyc(OP_LW, 0, 0, 0);
        check("to_fetch_wait", int'(state), 0);

        fetch_dec(6'h3f);
        cyc(6'h3f, 0, 0, 0);
        check("illegal_after", int'({state, illegal}), 0);

        fetch_dec(OP_SW);
        cyc(OP_SW, 0, 0, 0); tick();
        cyc(OP_SW, 0, 1, 1);
        check("rst_memwr", int'({state, mem_write}), 0);
        tick();
        cyc(OP_SW, 0, 1, 1); check("rst_hold_out", int'(mem_read), 0); tick();
        cyc(OP_RTYPE, 0, 1, 0);
        check("rst_resume", int'({state, ir_write}), 1);
        tick();

        for (int n = 0; n < 5000; n++) begin
            if (ms == FETCH && mw == 0) begin
                op   = ops[$urandom_range(0, 15)];
                slow = ($urandom_range(0, 9) == 0);
            end
            cyc(op,
                1'($urandom_range(0, 1)),
                slow ? ($urandom_range(0, 39) == 0)
                     : ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 199) == 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
